// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi
// Brief    : Multi-channel runtime-programmable clock divider. Each channel
//            counts clk_i cycles up to a programmable half-period and emits
//            either a 50% square wave or a one-cycle strobe, plus a
//            terminal-count tick. All outputs are registered clock-enable
//            style signals in the clk_i domain.
// Ports    : clk_i   - system clock, rising edge
//            rst_i   - synchronous reset, active low
//            en_i    - per-channel count enable
//            load_i  - per-channel half-period capture strobe
//            half_i  - packed half-periods, channel k at [k*CW +: CW]
//            mode_i  - per-channel mode, 0 = square, 1 = pulse
//            sync_i  - restart all channels phase-aligned
//            clk_o   - divided clock (square) or strobe (pulse)
//            tick_o  - one-cycle pulse at each terminal count
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module clk_div_multi #(
    parameter int              NCH      = 2,
    parameter int              CW       = 25,
    parameter logic [CW-1:0]   DEF_HALF = CW'(24_999_999)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NCH-1:0]      en_i,
    input  logic [NCH-1:0]      load_i,
    input  logic [NCH*CW-1:0]   half_i,
    input  logic [NCH-1:0]      mode_i,
    input  logic                sync_i,
    output logic [NCH-1:0]      clk_o,
    output logic [NCH-1:0]      tick_o
);

    localparam logic [CW-1:0] c_zero = '0;
    localparam logic [CW-1:0] c_one  = CW'(1);

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            logic [CW-1:0] r_half_q;
            logic [CW-1:0] r_cnt;
            logic          r_clk;
            logic          r_tick;
            logic          w_term;

            // The counter is cleared on every load, so it can never pass
            // r_half_q and equality is a safe terminal condition even at
            // the all-ones half-period.
            assign w_term = (r_cnt == r_half_q);

            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    r_half_q <= DEF_HALF;
                    r_cnt    <= c_zero;
                    r_clk    <= 1'b0;
                    r_tick   <= 1'b0;
                end else if (sync_i) begin
                    // Global restart: keep the programmed half-period so
                    // channels sharing a value come out phase-aligned.
                    r_cnt    <= c_zero;
                    r_clk    <= 1'b0;
                    r_tick   <= 1'b0;
                end else if (load_i[k]) begin
                    r_half_q <= half_i[k*CW +: CW];
                    r_cnt    <= c_zero;
                    r_tick   <= 1'b0;
                    // A square output keeps its level across a reload; a
                    // strobe must not linger past the cycle it marked.
                    if (mode_i[k]) begin
                        r_clk <= 1'b0;
                    end
                end else if (en_i[k]) begin
                    if (w_term) begin
                        r_cnt  <= c_zero;
                        r_tick <= 1'b1;
                        r_clk  <= mode_i[k] ? 1'b1 : ~r_clk;
                    end else begin
                        r_cnt  <= r_cnt + c_one;
                        r_tick <= 1'b0;
                        // Pulse mode drops the strobe; square mode holds.
                        if (mode_i[k]) begin
                            r_clk <= 1'b0;
                        end
                    end
                end else begin
                    r_tick <= 1'b0;
                end
            end

            assign clk_o[k]  = r_clk;
            assign tick_o[k] = r_tick;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_multi
// Brief    : Self-checking bench for clk_div_multi (NCH=2, CW=8, DEF_HALF=3).
//            Table-driven reset/startup vectors, directed corner sequences
//            and randomized traffic, all compared every cycle against a
//            behavioural model built on modular phase arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

    localparam int NCH      = 2;
    localparam int CW       = 8;
    localparam int DEF_HALF = 3;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [NCH-1:0]      en_i;
    logic [NCH-1:0]      load_i;
    logic [NCH*CW-1:0]   half_i;
    logic [NCH-1:0]      mode_i;
    logic                sync_i;
    logic [NCH-1:0]      clk_o;
    logic [NCH-1:0]      tick_o;

    clk_div_multi #(
        .NCH      (NCH),
        .CW       (CW),
        .DEF_HALF (8'(DEF_HALF))
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .load_i (load_i),
        .half_i (half_i),
        .mode_i (mode_i),
        .sync_i (sync_i),
        .clk_o  (clk_o),
        .tick_o (tick_o)
    );

    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------
    // Reference model: each channel is a phase position in [0, half]
    // that advances modulo (half+1); wrapping to 0 is a terminal count.
    // ------------------------------------------------------------------
    int unsigned     m_half  [NCH];
    int unsigned     m_phase [NCH];
    logic [NCH-1:0]  m_clk;
    logic [NCH-1:0]  m_tick;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void model_step();
        if (!rst_i) begin
            for (int k = 0; k < NCH; k++) begin
                m_half[k]  = DEF_HALF;
                m_phase[k] = 0;
            end
            m_clk  = '0;
            m_tick = '0;
        end else if (sync_i) begin
            for (int k = 0; k < NCH; k++) m_phase[k] = 0;
            m_clk  = '0;
            m_tick = '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (load_i[k]) begin
                    m_half[k]  = int'(half_i[k*CW +: CW]);
                    m_phase[k] = 0;
                    m_tick[k]  = 1'b0;
                    if (mode_i[k]) m_clk[k] = 1'b0;
                end else if (en_i[k]) begin
                    m_phase[k] = (m_phase[k] + 1) % (m_half[k] + 1);
                    m_tick[k]  = (m_phase[k] == 0);
                    if (mode_i[k]) m_clk[k] = m_tick[k];
                    else           m_clk[k] = m_clk[k] ^ m_tick[k];
                end else begin
                    m_tick[k] = 1'b0;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Advance one clock: model sees the inputs present at the edge, the
    // DUT is sampled 1 time unit after the edge.
    task automatic step();
        model_step();
        @(posedge clk_i);
        #1;
        check("model_clk",  {30'd0, clk_o},  {30'd0, m_clk});
        check("model_tick", {30'd0, tick_o}, {30'd0, m_tick});
    endtask

    typedef struct {
        logic           rst;
        logic [NCH-1:0] en;
        logic [NCH-1:0] exp_clk;
        logic [NCH-1:0] exp_tick;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int cnt0;
        int cnt1;
        logic frozen;

        // Reset, then 12 free-running cycles at half=3: ticks at 4, 8, 12.
        tbl[0]  = '{1'b0, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{1'b1, 2'b11, 2'b00, 2'b00};
        tbl[2]  = '{1'b1, 2'b11, 2'b00, 2'b00};
        tbl[3]  = '{1'b1, 2'b11, 2'b00, 2'b00};
        tbl[4]  = '{1'b1, 2'b11, 2'b11, 2'b11};
        tbl[5]  = '{1'b1, 2'b11, 2'b11, 2'b00};
        tbl[6]  = '{1'b1, 2'b11, 2'b11, 2'b00};
        tbl[7]  = '{1'b1, 2'b11, 2'b11, 2'b00};
        tbl[8]  = '{1'b1, 2'b11, 2'b00, 2'b11};
        tbl[9]  = '{1'b1, 2'b11, 2'b00, 2'b00};
        tbl[10] = '{1'b1, 2'b11, 2'b00, 2'b00};
        tbl[11] = '{1'b1, 2'b11, 2'b00, 2'b00};
        tbl[12] = '{1'b1, 2'b11, 2'b11, 2'b11};

        rst_i  = 1'b0;
        en_i   = '0;
        load_i = '0;
        half_i = '0;
        mode_i = '0;
        sync_i = 1'b0;

        // ---- 1. startup table ----
        for (int i = 0; i < 13; i++) begin
            rst_i = tbl[i].rst;
            en_i  = tbl[i].en;
            step();
            check("tbl_clk",  {30'd0, clk_o},  {30'd0, tbl[i].exp_clk});
            check("tbl_tick", {30'd0, tick_o}, {30'd0, tbl[i].exp_tick});
        end

        // ---- 2. simultaneous load: ch0 half=1, ch1 half=5 ----
        half_i = {8'd5, 8'd1};
        load_i = 2'b11;
        step();
        check("load_tick_clear", {30'd0, tick_o}, 32'd0);
        check("load_clk_hold",   {30'd0, clk_o},  32'd3);
        load_i = 2'b00;
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            cnt0 += int'(tick_o[0]);
            cnt1 += int'(tick_o[1]);
        end
        check("ch0_ticks_half1", cnt0, 6);
        check("ch1_ticks_half5", cnt1, 2);

        // ---- 3. pulse mode on ch1, half=2 then half=0 ----
        mode_i = 2'b10;
        half_i = {8'd2, 8'd1};
        load_i = 2'b10;
        step();
        check("pulse_load_clk0", {31'd0, clk_o[1]}, 32'd0);
        load_i = 2'b00;
        cnt1 = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            check("pulse_eq_tick", {31'd0, clk_o[1]}, {31'd0, tick_o[1]});
            cnt1 += int'(clk_o[1]);
        end
        check("pulse_1_in_3", cnt1, 3);
        half_i = {8'd0, 8'd1};
        load_i = 2'b10;
        step();
        load_i = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            check("pulse_half0_high", {31'd0, clk_o[1]}, 32'd1);
        end

        // ---- 4. freeze ch0 for 5 cycles ----
        mode_i = 2'b00;
        step();
        frozen = m_clk[0];
        en_i = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            check("freeze_clk0",  {31'd0, clk_o[0]},  {31'd0, frozen});
            check("freeze_tick0", {31'd0, tick_o[0]}, 32'd0);
        end
        en_i = 2'b11;
        for (int i = 0; i < 6; i++) step();

        // ---- 5. sync overrides load; equal halves align ----
        half_i = {8'd2, 8'd2};
        load_i = 2'b11;
        step();
        load_i = 2'b00;
        en_i   = 2'b10;
        step();
        en_i   = 2'b11;
        step();
        sync_i = 1'b1;
        load_i = 2'b01;
        half_i = {8'd2, 8'd7};
        step();
        check("sync_clk",  {30'd0, clk_o},  32'd0);
        check("sync_tick", {30'd0, tick_o}, 32'd0);
        sync_i = 1'b0;
        load_i = 2'b00;
        cnt0 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("sync_align", {31'd0, clk_o[0] ^ clk_o[1]}, 32'd0);
            cnt0 += int'(tick_o[0]);
        end
        check("sync_load_ignored", cnt0, 4);

        // ---- 6. reset glitch between edges, then real mid-period reset ----
        step();
        #1 rst_i = 1'b0;
        #2 rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();
        check("rst_clk",  {30'd0, clk_o},  32'd0);
        check("rst_tick", {30'd0, tick_o}, 32'd0);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("rst_pre_tick", {30'd0, tick_o}, 32'd0);
        step();
        check("rst_def_half", {30'd0, tick_o}, 32'd3);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            rst_i  = ($urandom_range(0, 99) != 0);
            sync_i = ($urandom_range(0, 49) == 0);
            en_i   = 2'($urandom_range(0, 3));
            for (int k = 0; k < NCH; k++) begin
                load_i[k] = ($urandom_range(0, 9) == 0);
                half_i[k*CW +: CW] = 8'($urandom_range(0, 6));
                if ($urandom_range(0, 19) == 0) mode_i[k] = ~mode_i[k];
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the team's fixed 100 MHz clock divider.
- Each channel divides clk_i by a runtime-programmable half-period.
- Each channel produces a divided clock level (square mode) or a one-cycle strobe (pulse mode), plus a terminal-count tick.
- Sits between the board clock and slower consumers (display scan, debounce, LED blink); the outputs are clock-enable-style signals on the clk_i domain.

Parameters:
- NCH, 2, number of independent divider channels.
- CW, 25, counter and half-period width in bits.
- DEF_HALF, 24_999_999, half-period loaded at reset. It gives 2 Hz square output from 100 MHz.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-low reset.
- en_i  input  NCH  per-channel count enable.
- load_i  input  NCH  per-channel strobe; captures the new half-period.
- half_i  input  NCH*CW  packed half-periods; channel k uses bits [k*CW +: CW].
- mode_i  input  NCH  per-channel mode: 0 = square, 1 = pulse.
- sync_i  input  1  restarts all channels phase-aligned.
- clk_o  output  NCH  divided clock (square mode) or strobe (pulse mode).
- tick_o  output  NCH  one-cycle pulse at each terminal count.

Behaviour:
- Per channel state:
  - half_q[CW]: reset value DEF_HALF.
  - cnt[CW]: reset value 0.
  - clk_o: reset value 0.
  - tick_o: reset value 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset: sampled only on the clk_i rising edge while rst_i = 0. It is honoured mid-period. The next cycle shows all reset values.
- Per-channel priority, highest first: reset > sync_i > load_i > count.
- sync_i = 1 (all channels): cnt <= 0, clk_o <= 0, tick_o <= 0. half_q is unchanged, and en_i and load_i are ignored that cycle.
- load_i[k] = 1 (no sync): half_q <= half_i slice, cnt <= 0, tick_o <= 0. clk_o holds in square mode and goes to 0 in pulse mode. The load applies even when en_i[k] = 0.
- Count, when en_i[k] = 1:
  - Terminal count is cnt == half_q. On terminal count: cnt <= 0, tick_o <= 1.
  - Otherwise: cnt <= cnt + 1, tick_o <= 0.
- en_i[k] = 0: cnt and clk_o hold, tick_o <= 0.
- Square mode: clk_o toggles on each terminal count.
  - Output period is 2*(half_q+1) cycles, 50% duty.
  - tick_o marks both edges, every half_q+1 cycles.
- Pulse mode: clk_o <= the terminal-count condition. It is high for exactly one cycle every half_q+1 cycles and equal to tick_o.
- half_q = 0:
  - tick_o stays high continuously while enabled.
  - Square mode: clk_o toggles every cycle (clk_i/2).
  - Pulse mode: clk_o stays high continuously.
- Counter wrap: cnt never exceeds half_q, because load clears cnt. No modular overflow occurs for any half_q up to 2^CW-1.
- Mode change mid-period: takes effect on the next cycle and cnt is not disturbed.
  - Square to pulse: clk_o drops to 0 unless that cycle is terminal.
  - Pulse to square: clk_o holds its current value, then toggles at the next terminal count.
- Simultaneous load_i on several channels: each channel updates independently in the same cycle.
- Channels share no state except sync_i and reset.

Test Plan:
1. Bench setting NCH=2, CW=8, DEF_HALF=3. Release reset, en_i=2'b11, mode_i=0 -> both clk_o toggle every 4 cycles (period 8); tick_o pulses at cycles 4, 8, 12 after release; clk_o is 0 before the first tick.
2. Ch0 half_i=1, ch1 half_i=5, load_i=2'b11 for one cycle -> ch0 period 4 cycles, ch1 period 12 cycles; both counters start from 0 on the cycle after load.
3. Ch1 mode_i=1, half=2 -> clk_o[1] is high 1 cycle in every 3 and matches tick_o[1] exactly; drive half=0 -> clk_o[1] stays high continuously.
4. Drop en_i[0] for 5 cycles mid-period -> cnt[0] and clk_o[0] freeze and tick_o[0] stays 0; on re-enable, counting resumes from the frozen value.
5. Assert sync_i while load_i=2'b01 -> load ignored, both channels cnt=0 and clk_o=0; after release, channels with equal half_q have identical clk_o waveforms.
6. Assert rst_i=0 mid-period for 1 cycle -> all outputs 0 and half_q=3 next cycle, regardless of prior loads; reset with no clk_i edge has no effect.
